// File: rtl/load_tid_allocator.sv
// Transaction-ID allocator for outstanding loads: hands out the lowest free ID,
// stores per-entry metadata, and releases entries when responses return.
module load_tid_allocator #(
  parameter int unsigned NrEntries = 2,
  parameter int unsigned MetaWidth = 8,
  localparam int unsigned IdWidth  = (NrEntries > 1) ? $clog2(NrEntries) : 1,
  localparam int unsigned CntWidth = $clog2(NrEntries + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 alloc_req_i,
  input  logic [MetaWidth-1:0] alloc_meta_i,
  output logic                 alloc_gnt_o,
  output logic [IdWidth-1:0]   alloc_id_o,
  input  logic                 free_valid_i,
  input  logic [IdWidth-1:0]   free_id_i,
  output logic [MetaWidth-1:0] free_meta_o,
  output logic                 free_err_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CntWidth-1:0]  count_o
);

  logic [NrEntries-1:0] valid_q;
  logic [NrEntries-1:0] valid_d;
  logic [MetaWidth-1:0] meta_q [NrEntries];
  logic                 free_hit;

  assign full_o      = &valid_q;
  assign empty_o     = ~|valid_q;
  assign alloc_gnt_o = alloc_req_i & ~full_o & ~flush_i;
  // Out-of-range IDs never match an entry, so they read as invalid.
  assign free_err_o  = free_valid_i & ~free_hit;

  always_comb begin
    alloc_id_o  = '0;
    free_hit    = 1'b0;
    free_meta_o = '0;
    count_o     = '0;
    for (int i = NrEntries - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_id_o = IdWidth'(i);
    end
    for (int i = 0; i < NrEntries; i++) begin
      if (free_id_i == IdWidth'(i)) begin
        free_hit    = valid_q[i];
        free_meta_o = meta_q[i];
      end
      count_o = count_o + CntWidth'(valid_q[i]);
    end
  end

  // Freed entry and granted entry can never coincide: the grant always targets an invalid slot.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < NrEntries; i++) begin
        if (free_valid_i && !free_err_o && free_id_i == IdWidth'(i)) valid_d[i] = 1'b0;
        if (alloc_gnt_o && alloc_id_o == IdWidth'(i)) valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < NrEntries; i++) meta_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NrEntries; i++) begin
        if (alloc_gnt_o && alloc_id_o == IdWidth'(i)) meta_q[i] <= alloc_meta_i;
      end
    end
  end

endmodule

// File: tb/tb_load_tid_allocator.sv
// Table-driven bench for load_tid_allocator (2 entries, 8-bit metadata) with
// queued expectations for combinational and post-edge results.
module tb_load_tid_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, req, fv, gnt, id, fid, ferr, full, empty;
  logic [7:0] meta, fmeta;
  logic [1:0] cnt;

  load_tid_allocator #(.NrEntries(2), .MetaWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .alloc_req_i(req),
    .alloc_meta_i(meta), .alloc_gnt_o(gnt), .alloc_id_o(id),
    .free_valid_i(fv), .free_id_i(fid), .free_meta_o(fmeta),
    .free_err_o(ferr), .full_o(full), .empty_o(empty), .count_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic flush; logic req; logic [7:0] meta; logic fv; logic fid;
    logic gnt; logic id; logic [7:0] fmeta; logic ferr;
    logic [1:0] cnt; logic full; logic empty;
  } vec_t;
  typedef struct { logic gnt; logic id; logic [7:0] fmeta; logic ferr; } comb_t;
  typedef struct { logic [1:0] cnt; logic full; logic empty; } post_t;

  vec_t  vecs[$];
  comb_t comb_q[$];
  post_t post_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic rq, input logic [7:0] m,
                              input logic v, input logic f, input logic g, input logic i,
                              input logic [7:0] fm, input logic fe, input logic [1:0] c,
                              input logic fu, input logic em);
    vec_t t;
    t.flush = fl; t.req = rq; t.meta = m; t.fv = v; t.fid = f;
    t.gnt = g; t.id = i; t.fmeta = fm; t.ferr = fe; t.cnt = c; t.full = fu; t.empty = em;
    return t;
  endfunction

  task automatic drive(input logic fl, input logic rq, input logic [7:0] m,
                       input logic v, input logic f);
    flush = fl; req = rq; meta = m; fv = v; fid = f;
  endtask

  task automatic check_comb(input string tag);
    comb_t c;
    c = comb_q.pop_front();
    check({tag, ".gnt"},   {7'd0, gnt},  {7'd0, c.gnt});
    check({tag, ".id"},    {7'd0, id},   {7'd0, c.id});
    check({tag, ".fmeta"}, fmeta,        c.fmeta);
    check({tag, ".ferr"},  {7'd0, ferr}, {7'd0, c.ferr});
  endtask

  task automatic check_post(input string tag);
    post_t p;
    p = post_q.pop_front();
    check({tag, ".count"}, {6'd0, cnt},   {6'd0, p.cnt});
    check({tag, ".full"},  {7'd0, full},  {7'd0, p.full});
    check({tag, ".empty"}, {7'd0, empty}, {7'd0, p.empty});
  endtask

  initial begin
    //           fl rq meta  fv fid | gnt id fmeta ferr | cnt full empty
    vecs.push_back(mk(0, 1, 8'hA5, 0, 0, 1, 0, 8'h00, 0, 2'd1, 0, 0)); // first alloc
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 8'hA5, 0, 2'd0, 0, 1)); // free id0
    vecs.push_back(mk(0, 1, 8'h11, 0, 0, 1, 0, 8'hA5, 0, 2'd1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 0, 1, 1, 8'h11, 0, 2'd2, 1, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 0, 0, 0, 8'h11, 0, 2'd2, 1, 0)); // full deny
    vecs.push_back(mk(0, 1, 8'h55, 1, 0, 0, 0, 8'h11, 0, 2'd1, 0, 0)); // full + free
    vecs.push_back(mk(0, 1, 8'h66, 0, 1, 1, 0, 8'h22, 0, 2'd2, 1, 0)); // reuse id0
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h22, 0, 2'd1, 0, 0)); // free id1
    vecs.push_back(mk(0, 1, 8'h33, 1, 0, 1, 1, 8'h66, 0, 2'd1, 0, 0)); // alloc+free
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 8'h66, 1, 2'd1, 0, 0)); // err: id0 invalid
    vecs.push_back(mk(0, 1, 8'h77, 0, 1, 1, 0, 8'h33, 0, 2'd2, 1, 0));
    vecs.push_back(mk(1, 1, 8'h88, 1, 1, 0, 0, 8'h33, 0, 2'd0, 0, 1)); // flush wins
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 8'h77, 1, 2'd0, 0, 1)); // flush, err pre-state
    vecs.push_back(mk(0, 1, 8'h99, 0, 0, 1, 0, 8'h77, 0, 2'd1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 0, 1, 8'h33, 1, 2'd1, 0, 0)); // err: id1 invalid
    vecs.push_back(mk(0, 1, 8'hAB, 1, 1, 1, 1, 8'h33, 1, 2'd2, 1, 0)); // free==alloc_id

    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 1);
    #12;
    post_q.push_back('{cnt: 2'd0, full: 1'b0, empty: 1'b1});
    check_post("reset");
    check("reset.fmeta", fmeta, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      @(negedge clk);
      drive(vecs[k].flush, vecs[k].req, vecs[k].meta, vecs[k].fv, vecs[k].fid);
      comb_q.push_back('{gnt: vecs[k].gnt, id: vecs[k].id, fmeta: vecs[k].fmeta, ferr: vecs[k].ferr});
      post_q.push_back('{cnt: vecs[k].cnt, full: vecs[k].full, empty: vecs[k].empty});
      #1 check_comb(tag);
      @(posedge clk);
      #1 check_post(tag);
    end

    // Asynchronous reset with both entries valid: outputs clear before any edge.
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 1);
    #2 rst = 1'b1;
    #1;
    post_q.push_back('{cnt: 2'd0, full: 1'b0, empty: 1'b1});
    check_post("async_rst");
    check("async_rst.fmeta", fmeta, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // First cycle after reset release allocates normally.
    drive(0, 1, 8'hC3, 0, 0);
    comb_q.push_back('{gnt: 1'b1, id: 1'b0, fmeta: 8'h00, ferr: 1'b0});
    post_q.push_back('{cnt: 2'd1, full: 1'b0, empty: 1'b0});
    #1 check_comb("post_rst");
    @(posedge clk);
    #1 check_post("post_rst");
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0);
    #1 check("post_rst.meta", fmeta, 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_tid_allocator.md
LOAD_TID_ALLOCATOR -- requirements
Module: load_tid_allocator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter NrEntries, default 2: number of trackable outstanding load transactions; legal range 1..16.
REQ-003 Parameter MetaWidth, default 8: width of per-entry metadata (e.g. byte offset and size); legal range 1..64.
REQ-004 Derived IdWidth = max(1, clog2(NrEntries)); derived CntWidth = clog2(NrEntries+1).
REQ-005 clk_i  in  1  clock, rising edge.
REQ-006 rst_i  in  1  asynchronous reset, active high.
REQ-007 flush_i  in  1  drop all outstanding entries.
REQ-008 alloc_req_i  in  1  request a new transaction ID.
REQ-009 alloc_meta_i  in  MetaWidth  metadata stored with the allocated entry.
REQ-010 alloc_gnt_o  out  1  allocation accepted this cycle.
REQ-011 alloc_id_o  out  IdWidth  allocated ID; meaningful only when alloc_gnt_o=1.
REQ-012 free_valid_i  in  1  a response returns and releases free_id_i.
REQ-013 free_id_i  in  IdWidth  ID being released.
REQ-014 free_meta_o  out  MetaWidth  metadata stored at free_id_i.
REQ-015 free_err_o  out  1  free of an unallocated or out-of-range ID.
REQ-016 full_o, empty_o  out  1 each  no free entry / no valid entry.
REQ-017 count_o  out  CntWidth  number of valid entries.

Function
REQ-018 State SHALL be a registered valid vector valid_q[NrEntries] plus a registered meta array meta_q[NrEntries][MetaWidth].
REQ-019 full_o = &valid_q, empty_o = ~|valid_q, count_o = popcount(valid_q); all derived from registered state only.
REQ-020 alloc_gnt_o = alloc_req_i & ~full_o & ~flush_i, combinational, zero-cycle latency.
REQ-021 alloc_id_o = lowest index i with valid_q[i]=0; when full, alloc_id_o = 0.
REQ-022 On a rising edge with alloc_gnt_o=1: valid_q[alloc_id_o] <= 1, meta_q[alloc_id_o] <= alloc_meta_i.
REQ-023 free_meta_o = meta_q[free_id_i], combinational; 0 when free_id_i >= NrEntries.
REQ-024 free_err_o = free_valid_i & (free_id_i >= NrEntries | ~valid_q[free_id_i]), combinational.
REQ-025 On a rising edge with free_valid_i=1, free_err_o=0, flush_i=0: valid_q[free_id_i] <= 0; meta_q unchanged.
REQ-026 An erroneous free SHALL cause no state change.
REQ-027 Simultaneous alloc and free: both take effect on the same edge; the freed entry is not reusable until the next cycle; count_o is unchanged.
REQ-028 A full allocator with a concurrent valid free SHALL still deny allocation that cycle (alloc_gnt_o=0).
REQ-029 flush_i=1 SHALL clear all valid_q on the next edge, overriding any alloc or free that cycle; free_err_o still reflects pre-flush state.
REQ-030 A free of an ID equal to alloc_id_o in the same cycle is impossible by construction (that entry is invalid) and SHALL flag free_err_o.

Reset
REQ-031 While rst_i=1: valid_q=0 and meta_q=0, asynchronously; hence empty_o=1, full_o=0, count_o=0, free_meta_o=0.
REQ-032 Mid-operation reset SHALL discard all outstanding entries; the first edge after deassertion operates normally.

Verification (NrEntries=2, MetaWidth=8)
REQ-033 Reset, then alloc_req_i=1 with meta 0xA5 -> gnt=1, id=0; next cycle count_o=1, empty_o=0; free id0 -> free_meta_o=0xA5, next cycle empty_o=1.
REQ-034 Two back-to-back allocs (0x11, 0x22) -> ids 0,1; third cycle full_o=1 and alloc_req_i=1 gives gnt=0.
REQ-035 Full with free id0 plus alloc_req_i in the same cycle -> gnt=0, count_o goes 2->1; next cycle alloc gets id=0.
REQ-036 One valid entry (id0) with simultaneous free id0 and alloc (meta 0x33) -> alloc_id_o=1, count_o stays 1, then valid_q=2'b10.
REQ-037 Free of id1 while only id0 is valid -> free_err_o=1, count_o unchanged; flush with 2 valid plus alloc_req_i -> gnt=0, next cycle count_o=0.
REQ-038 Assert rst_i asynchronously with 2 valid entries -> outputs take reset values before the next clock edge.
